simon_key_sched: RTL and testbench

- Sequential SIMON key-expansion engine. Loads an m-word master key and expands it into T round keys, one per clock, into an internal register file.
- Streams the round keys out over a valid/ready interface, in forward order for encryption or reverse order for decryption.
- Sits directly upstream of the combinational inverse-round stage and drives its k input, one key per round, from k[T-1] down to k[0].

---
 rtl/simon_key_sched.sv | 214 +++++++++++++++++++++
 tb/tb_simon_key_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_key_sched.sv
// SIMON 32/64 key-expansion engine: expands a 4-word master key into T round keys and
// streams them forward or reverse. Optional macro SIMON_KS_ZEROIZE_EN clears key slots.
module simon_key_sched #(
    parameter int          N     = 16,
    parameter int          M     = 4,
    parameter int          T     = 32,
    parameter logic [61:0] Z_SEQ = 62'b11111010001001010110000111001101111101000100101011000011100110
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M*N-1:0] key_in,
    input  logic           key_valid,
    output logic           key_ready,
    output logic           keys_ok,
    input  logic           start,
    input  logic           dir,
    output logic [N-1:0]   rk_data,
    output logic [4:0]     rk_idx,
    output logic           rk_valid,
    input  logic           rk_ready,
    output logic           rk_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2,
        STREAM = 2'd3
    } state_t;

    function automatic logic [N-1:0] ror1(input logic [N-1:0] v);
        return {v[0], v[N-1:1]};
    endfunction

    function automatic logic [N-1:0] ror3(input logic [N-1:0] v);
        return {v[2:0], v[N-1:3]};
    endfunction

    state_t         state_r, state_s;
    logic [4:0]     cnt_r, cnt_s;
    logic [4:0]     ptr_r, ptr_s;
    logic           dir_r, dir_s;
    logic           key_ready_r, key_ready_s;
    logic           keys_ok_r, keys_ok_s;
    logic           rk_valid_r, rk_valid_s;
    logic           rk_last_r, rk_last_s;
    logic [N-1:0]   rk_data_r, rk_data_s;
    logic           load_s;
    logic           exp_we_s;
`ifdef SIMON_KS_ZEROIZE_EN
    logic           clr_s;
`endif

    logic [N-1:0]   key_r [T];
    logic [N-1:0]   t_s;
    logic [N-1:0]   exp_key_s;
    logic [5:0]     zidx_s;
    logic           z_s;

    // New key word: ~k[i-4] ^ t ^ (t ror 1) ^ z_(i-4) ^ 3, with t = (k[i-1] ror 3) ^ k[i-3].
    assign t_s       = ror3(key_r[cnt_r - 5'd1]) ^ key_r[cnt_r - 5'd3];
    assign zidx_s    = 6'd61 - {1'b0, cnt_r - 5'd4};
    assign z_s       = Z_SEQ[zidx_s];
    assign exp_key_s = ~key_r[cnt_r - 5'd4] ^ t_s ^ ror1(t_s)
                       ^ {{(N-1){1'b0}}, z_s} ^ {{(N-2){1'b0}}, 2'b11};

    // Next-state and next-output logic for the engine.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        ptr_s       = ptr_r;
        dir_s       = dir_r;
        key_ready_s = key_ready_r;
        keys_ok_s   = keys_ok_r;
        rk_valid_s  = rk_valid_r;
        rk_last_s   = rk_last_r;
        rk_data_s   = rk_data_r;
        load_s      = 1'b0;
        exp_we_s    = 1'b0;
`ifdef SIMON_KS_ZEROIZE_EN
        clr_s       = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (key_valid) begin
                    load_s      = 1'b1;
                    cnt_s       = 5'(M);
                    key_ready_s = 1'b0;
                    state_s     = EXPAND;
                end else begin
                    key_ready_s = 1'b1;
                end
            end
            EXPAND: begin
                exp_we_s = 1'b1;
                if (cnt_r == 5'(T-1)) begin
                    key_ready_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    cnt_s = cnt_r + 5'd1;
                end
            end
            DONE: begin
                // keys_ok rises one cycle after entry; a new key always beats start.
                if (key_valid) begin
                    load_s      = 1'b1;
                    cnt_s       = 5'(M);
                    keys_ok_s   = 1'b0;
                    key_ready_s = 1'b0;
                    state_s     = EXPAND;
                end else if (start && keys_ok_r) begin
                    ptr_s       = dir ? 5'(T-1) : 5'd0;
                    dir_s       = dir;
                    rk_data_s   = key_r[ptr_s];
                    rk_valid_s  = 1'b1;
                    rk_last_s   = 1'b0;
                    key_ready_s = 1'b0;
                    state_s     = STREAM;
                end else begin
                    keys_ok_s = 1'b1;
                end
            end
            STREAM: begin
                if (rk_valid_r && rk_ready) begin
                    if (rk_last_r) begin
                        rk_valid_s  = 1'b0;
                        rk_last_s   = 1'b0;
                        key_ready_s = 1'b1;
                        state_s     = DONE;
`ifdef SIMON_KS_ZEROIZE_EN
                        if (dir_r) begin
                            clr_s     = 1'b1;
                            keys_ok_s = 1'b0;
                            state_s   = IDLE;
                        end else begin
                            keys_ok_s = 1'b1;
                        end
`endif
                    end else begin
                        ptr_s     = dir_r ? (ptr_r - 5'd1) : (ptr_r + 5'd1);
                        rk_data_s = key_r[ptr_s];
                        rk_last_s = (ptr_s == (dir_r ? 5'd0 : 5'(T-1)));
                    end
                end else begin
                    rk_valid_s = rk_valid_r;
                end
            end
            default: begin
                state_s     = IDLE;
                key_ready_s = 1'b1;
                keys_ok_s   = 1'b0;
                rk_valid_s  = 1'b0;
                rk_last_s   = 1'b0;
            end
        endcase
    end

    // Control state and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 5'd0;
            ptr_r       <= 5'd0;
            dir_r       <= 1'b0;
            key_ready_r <= 1'b1;
            keys_ok_r   <= 1'b0;
            rk_valid_r  <= 1'b0;
            rk_last_r   <= 1'b0;
            rk_data_r   <= {N{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            ptr_r       <= ptr_s;
            dir_r       <= dir_s;
            key_ready_r <= key_ready_s;
            keys_ok_r   <= keys_ok_s;
            rk_valid_r  <= rk_valid_s;
            rk_last_r   <= rk_last_s;
            rk_data_r   <= rk_data_s;
        end
    end

`ifdef SIMON_KS_ZEROIZE_EN
    // Round-key register file, cleared on reset, on key load and after a decrypt stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < T; i++) key_r[i] <= {N{1'b0}};
        end else if (clr_s) begin
            for (int i = 0; i < T; i++) key_r[i] <= {N{1'b0}};
        end else if (load_s) begin
            for (int i = 0; i < T; i++) key_r[i] <= (i < M) ? key_in[i*N +: N] : {N{1'b0}};
        end else if (exp_we_s) begin
            key_r[cnt_r] <= exp_key_s;
        end
    end
`else
    // Round-key register file; contents persist until overwritten.
    always_ff @(posedge clk) begin
        if (load_s) begin
            for (int i = 0; i < M; i++) key_r[i] <= key_in[i*N +: N];
        end else if (exp_we_s) begin
            key_r[cnt_r] <= exp_key_s;
        end
    end
`endif

    assign key_ready = key_ready_r;
    assign keys_ok   = keys_ok_r;
    assign rk_valid  = rk_valid_r;
    assign rk_last   = rk_last_r;
    assign rk_data   = rk_data_r;
    assign rk_idx    = ptr_r;

endmodule

// File: tb/tb_simon_key_sched.sv
// Self-checking bench for simon_key_sched: arithmetic key-schedule model, stream scoreboard
// checked every cycle, and a SIMON 32/64 inverse-round chain fed by the streamed keys.
module tb_simon_key_sched;

    localparam logic [61:0] ZS = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [63:0] K1 = 64'h1918_1110_0908_0100;
    localparam logic [63:0] K2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [31:0] PT = 32'h6565_6877;
    localparam logic [31:0] CT = 32'hC69B_E9BB;

    typedef struct packed {
        logic [4:0]  idx;
        logic [15:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = 64'd0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic        keys_ok;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] rk_data;
    logic [4:0]  rk_idx;
    logic        rk_valid;
    logic        rk_ready = 1'b0;
    logic        rk_last;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_k [32];
    beat_t       exp_q [$];
    logic [15:0] got_q [$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'd0;
    logic [4:0]  prev_idx = 5'd0;

    simon_key_sched dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .keys_ok(keys_ok), .start(start), .dir(dir),
        .rk_data(rk_data), .rk_idx(rk_idx), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .rk_last(rk_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rol(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] rf(input logic [15:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    function automatic void model_expand(input logic [63:0] k);
        logic [15:0] t;
        for (int i = 0; i < 4; i++) model_k[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t = rol(model_k[i-1], 13) ^ model_k[i-3];
            model_k[i] = 16'hFFFC ^ model_k[i-4] ^ t ^ rol(t, 15) ^ {15'd0, ZS[61-(i-4)]};
        end
    endfunction

    function automatic logic [31:0] encrypt(input logic [31:0] p);
        logic [15:0] x, y, tmp;
        x = p[31:16];
        y = p[15:0];
        for (int i = 0; i < 32; i++) begin
            tmp = x;
            x   = y ^ rf(x) ^ model_k[i];
            y   = tmp;
        end
        return {x, y};
    endfunction

    // Inverse-round chain driven with keys in the order given.
    function automatic logic [31:0] decrypt_chain(input logic [31:0] c, input logic [15:0] ks [$]);
        logic [15:0] x, y, nx;
        x = c[31:16];
        y = c[15:0];
        foreach (ks[i]) begin
            nx = y;
            y  = x ^ rf(y) ^ ks[i];
            x  = nx;
        end
        return {x, y};
    endfunction

    // Scoreboard: every valid beat is compared; stalled beats must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rk_valid) begin
                if (prev_stall) begin
                    check("stall_data_stable", rk_data, prev_data);
                    check("stall_idx_stable", rk_idx, prev_idx);
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    check("rk_idx", rk_idx, exp_q[0].idx);
                    check("rk_data", rk_data, exp_q[0].data);
                    check("rk_last", rk_last, exp_q[0].last);
                    if (rk_ready) begin
                        got_q.push_back(rk_data);
                        void'(exp_q.pop_front());
                    end
                end
            end else if (prev_stall) begin
                check("valid_dropped", rk_valid, 1);
            end
            prev_stall = rk_valid && !rk_ready;
            prev_data  = rk_data;
            prev_idx   = rk_idx;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_key_ready"}, key_ready, 1);
        check({tag, "_keys_ok"}, keys_ok, 0);
        check({tag, "_rk_valid"}, rk_valid, 0);
        check({tag, "_rk_last"}, rk_last, 0);
        check({tag, "_rk_data"}, rk_data, 0);
        check({tag, "_rk_idx"}, rk_idx, 0);
    endtask

    task automatic load_key(input logic [63:0] k, input logic with_start);
        int n;
        check("key_ready_before_load", key_ready, 1);
        key_in = k; key_valid = 1'b1; start = with_start; dir = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b0; start = 1'b0;
        check("accept_keys_ok_low", keys_ok, 0);
        check("accept_key_ready_low", key_ready, 0);
        check("accept_no_stream", rk_valid, 0);
        model_expand(k);
        n = 0;
        while (!keys_ok && n < 100) begin
            start = (n == 5);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("keys_ok_latency", n, 29);
        check("key_ready_in_done", key_ready, 1);
        check("no_stream_from_expand_start", rk_valid, 0);
    endtask

    task automatic run_stream(input logic d, input int rmode);
        int n;
        int idx;
        for (int b = 0; b < 32; b++) begin
            idx = d ? 31 - b : b;
            exp_q.push_back('{idx[4:0], model_k[idx], b == 31});
        end
        got_q.delete();
        start = 1'b1; dir = d; rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            rk_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("stream_all_beats", exp_q.size(), 0);
        check("valid_low_after_stream", rk_valid, 0);
        check("beats_received", got_q.size(), 32);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] res;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst_n = 1'b1;

        model_expand(K1);
        check("model_k0", model_k[0], 16'h0100);
        check("model_k1", model_k[1], 16'h0908);
        check("model_k2", model_k[2], 16'h1110);
        check("model_k3", model_k[3], 16'h1918);
        check("model_k4", model_k[4], 16'h71C3);
        check("model_encrypt", encrypt(PT), CT);

        load_key(K1, 1'b0);
        run_stream(1'b0, 0);
        run_stream(1'b1, 0);
        res = decrypt_chain(CT, got_q);
        check("decrypt_chain", res, PT);
`ifdef SIMON_KS_ZEROIZE_EN
        check("zeroize_keys_ok", keys_ok, 0);
        check("zeroize_key_ready", key_ready, 1);
        load_key(K1, 1'b0);
`endif
        run_stream(1'b0, 1);
        run_stream(1'b1, 1);

        // Reset during expansion, ten cycles after accept.
        key_in = K2; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_expand");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("keys_ok_after_rst_expand", keys_ok, 0);

        load_key(K1, 1'b0);
        for (int b = 0; b < 32; b++) exp_q.push_back('{5'(b), model_k[b], b == 31});
        start = 1'b1; dir = 1'b0; rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("beat7_idx", rk_idx, 7);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_stream");
        exp_q.delete();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("keys_ok_after_rst_stream", keys_ok, 0);

        load_key(K1, 1'b0);
        run_stream(1'b1, 0);
        res = decrypt_chain(CT, got_q);
        check("decrypt_after_reload", res, PT);

        // key_valid with start in DONE: re-expansion, no stream.
        load_key(K2, 1'b1);
        run_stream(1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
